xor_end: RTL and testbench

// - ASCON end-of-permutation key XOR stage: adds the 128-bit key into the last two state words.
// - Sits after the permutation round, before the state register/output mux of the ASCON AEAD128 datapath.
// - Uses the ascon_pack::type_state 5x64-bit state type, word 0 first.
// - Result is registered; one clock domain.

---
 rtl/xor_end.sv | 41 ++++
 tb/tb_xor_end.sv | 136 +++++++++++++
 2 files changed

// File: rtl/xor_end.sv
// ASCON end-of-permutation key add: XORs the 128-bit key into state words 3 and 4.
// Latency is 1 cycle. There is no backpressure: a new state is accepted on every clock edge.
package ascon_pack;
  // Word 0 is S[0]. Indexing is [word][bit].
  typedef logic [4:0][63:0] type_state;
endpackage

module xor_end
  import ascon_pack::*;
(
  input  logic           clock_i,
  input  logic           resetb_i,
  input  logic [127:0]   data_i,
  input  logic           enable_xe_i,
  input  type_state      state_i,
  output type_state      output_mux_o
);

  type_state state_d;
  type_state state_q;

  // The high half of the key goes into S[3] and the low half into S[4].
  always_comb begin
    state_d = state_i;
    if (enable_xe_i) begin
      state_d[3] = state_i[3] ^ data_i[127:64];
      state_d[4] = state_i[4] ^ data_i[63:0];
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign output_mux_o = state_q;

endmodule

// File: tb/tb_xor_end.sv
// Directed-vector bench for xor_end, using hand-computed expected states.
module tb_xor_end;
  import ascon_pack::*;

  logic         clock_i;
  logic         resetb_i;
  logic [127:0] data_i;
  logic         enable_xe_i;
  type_state    state_i;
  type_state    output_mux_o;

  int n_checks;
  int n_fail;

  localparam logic [127:0] KEY = 128'h691AED630E81901F6CB10AD9CA912F80;

  type_state s_ref;
  type_state s_xor;
  type_state s_zero;
  type_state s_ones_exp;

  xor_end dut (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .data_i       (data_i),
    .enable_xe_i  (enable_xe_i),
    .state_i      (state_i),
    .output_mux_o (output_mux_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %016h expected %016h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input type_state exp);
    for (int k = 0; k < 5; k++)
      chk($sformatf("%s.w%0d", tag, k), output_mux_o[k], exp[k]);
  endtask

  // Advance one rising edge and sample slightly after it.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    s_ref[0] = 64'h82bf91294ba5808d;
    s_ref[1] = 64'hd81eeca694136f8a;
    s_ref[2] = 64'h0217bc9ebd9fff02;
    s_ref[3] = 64'h4dd2c87c59c2fb48;
    s_ref[4] = 64'h4e2b20c3e9eb3044;

    s_xor[0] = 64'h82bf91294ba5808d;
    s_xor[1] = 64'hd81eeca694136f8a;
    s_xor[2] = 64'h0217bc9ebd9fff02;
    s_xor[3] = 64'h24c8251f57436b57;
    s_xor[4] = 64'h229a2a1a237a1fc4;

    s_zero = '0;
    s_ones_exp[0] = 64'h0;
    s_ones_exp[1] = 64'h0;
    s_ones_exp[2] = 64'h0;
    s_ones_exp[3] = 64'hFFFFFFFFFFFFFFFF;
    s_ones_exp[4] = 64'hFFFFFFFFFFFFFFFF;

    // Reset with non-zero inputs driven.
    resetb_i    = 1'b0;
    enable_xe_i = 1'b1;
    data_i      = KEY;
    state_i     = s_ref;
    step();
    step();
    chk_state("reset", s_zero);

    // Key XOR.
    resetb_i    = 1'b1;
    enable_xe_i = 1'b1;
    step();
    chk_state("xor", s_xor);

    // Bypass.
    enable_xe_i = 1'b0;
    step();
    chk_state("bypass", s_ref);

    // Toggle 1,0,1. The output lags the select by one edge.
    enable_xe_i = 1'b1;
    step();
    chk_state("tog1", s_xor);
    enable_xe_i = 1'b0;
    chk_state("tog_hold", s_xor);
    step();
    chk_state("tog0", s_ref);
    enable_xe_i = 1'b1;
    step();
    chk_state("tog2", s_xor);

    // Reset in the middle of a stream, with enable held high.
    resetb_i = 1'b0;
    step();
    chk_state("midrst", s_zero);
    resetb_i = 1'b1;
    step();
    chk_state("post_rst", s_xor);

    // Boundary: an all-ones key applied to a zero state.
    data_i  = {128{1'b1}};
    state_i = s_zero;
    step();
    chk_state("ones", s_ones_exp);

    // Boundary: a zero key is the identity in both modes.
    data_i      = '0;
    state_i     = s_ref;
    enable_xe_i = 1'b1;
    step();
    chk_state("zkey_en", s_ref);
    enable_xe_i = 1'b0;
    step();
    chk_state("zkey_byp", s_ref);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
